// File: rtl/riscv_m_pkg.sv
// Shared definitions for the RV32M multiply/divide units: funct3 codes and
// the divider sequencing states.
package riscv_m_pkg;

  // Multiplier operation codes (funct3 with funct7 = 0000001)
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;

  // Divider operation codes
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // Divider sequencing states
  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_CALC = 2'b01,
    DIV_SIGN = 2'b10,
    DIV_DONE = 2'b11
  } div_state_t;

endpackage

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Works on magnitudes, fixes up signs in a final SIGN cycle, and answers
// the EX-stage issue/busy handshake (ce in, busy out).
module div_unit
  import riscv_m_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES    = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZRO = {CNT_W{1'b0}};

  // Registered state. The stored remainder is always below the divisor, so
  // WIDTH bits suffice; the extra borrow bit only exists in the trial value.
  div_state_t       state_r;
  logic [WIDTH-1:0] result_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] dvsr_r;
  logic [CNT_W-1:0] cnt_r;
  logic             neg_q_r;
  logic             neg_r_r;
  logic             sel_rem_r;

  // Next-state values
  div_state_t       state_s;
  logic [WIDTH-1:0] result_s;
  logic [WIDTH-1:0] rem_s;
  logic [WIDTH-1:0] quo_s;
  logic [WIDTH-1:0] dvsr_s;
  logic [CNT_W-1:0] cnt_s;
  logic             neg_q_s;
  logic             neg_r_s;
  logic             sel_rem_s;
  logic             busy_s;

  // Datapath helpers
  logic             is_signed_s;
  logic [WIDTH-1:0] abs_a_s;
  logic [WIDTH-1:0] abs_b_s;
  logic             div0_s;
  logic             ovf_s;
  logic [WIDTH:0]   shift_s;
  logic [WIDTH:0]   diff_s;
  logic [WIDTH-1:0] quo_fix_s;
  logic [WIDTH-1:0] rem_fix_s;

  // Operand conditioning, one restoring step and the final sign fix-up
  always_comb begin
    is_signed_s = funct3[2] & ~funct3[0];
    if (is_signed_s && a[WIDTH-1]) begin
      abs_a_s = ~a + ONE;
    end else begin
      abs_a_s = a;
    end
    if (is_signed_s && b[WIDTH-1]) begin
      abs_b_s = ~b + ONE;
    end else begin
      abs_b_s = b;
    end
    div0_s  = (b == ZERO);
    ovf_s   = is_signed_s & (a == MIN_NEG) & (b == ONES);
    // Shift {rem, quo} left by one; the trial difference borrows into bit WIDTH
    shift_s = {rem_r, quo_r[WIDTH-1]};
    diff_s  = shift_s - {1'b0, dvsr_r};
    if (neg_q_r) begin
      quo_fix_s = ~quo_r + ONE;
    end else begin
      quo_fix_s = quo_r;
    end
    if (neg_r_r) begin
      rem_fix_s = ~rem_r + ONE;
    end else begin
      rem_fix_s = rem_r;
    end
  end

  // Next-state, datapath update and busy decode
  always_comb begin
    state_s   = state_r;
    result_s  = result_r;
    rem_s     = rem_r;
    quo_s     = quo_r;
    dvsr_s    = dvsr_r;
    cnt_s     = cnt_r;
    neg_q_s   = neg_q_r;
    neg_r_s   = neg_r_r;
    sel_rem_s = sel_rem_r;
    busy_s    = 1'b0;

    case (state_r)
      DIV_IDLE: begin
        busy_s = ce;
        if (ce) begin
          dvsr_s    = abs_b_s;
          quo_s     = abs_a_s;
          rem_s     = ZERO;
          cnt_s     = CNT_MAX;
          neg_q_s   = (a[WIDTH-1] ^ b[WIDTH-1]) & is_signed_s;
          neg_r_s   = a[WIDTH-1] & is_signed_s;
          sel_rem_s = funct3[1];
          if (!funct3[2]) begin
            // Not a divide code: answer zero without iterating
            result_s = ZERO;
            state_s  = DIV_DONE;
          end else if (div0_s) begin
            result_s = funct3[1] ? a : ONES;
            state_s  = DIV_DONE;
          end else if (ovf_s) begin
            result_s = funct3[1] ? ZERO : MIN_NEG;
            state_s  = DIV_DONE;
          end else begin
            state_s = DIV_CALC;
          end
        end else begin
          state_s = DIV_IDLE;
        end
      end
      DIV_CALC: begin
        busy_s = ce;
        if (!ce) begin
          // Pipeline flush: abandon the divide, result untouched
          state_s = DIV_IDLE;
        end else begin
          if (!diff_s[WIDTH]) begin
            rem_s = diff_s[WIDTH-1:0];
            quo_s = {quo_r[WIDTH-2:0], 1'b1};
          end else begin
            rem_s = shift_s[WIDTH-1:0];
            quo_s = {quo_r[WIDTH-2:0], 1'b0};
          end
          if (cnt_r == CNT_ZRO) begin
            state_s = DIV_SIGN;
          end else begin
            cnt_s = cnt_r - CNT_ONE;
          end
        end
      end
      DIV_SIGN: begin
        busy_s = ce;
        if (!ce) begin
          state_s = DIV_IDLE;
        end else begin
          result_s = sel_rem_r ? rem_fix_s : quo_fix_s;
          state_s  = DIV_DONE;
        end
      end
      DIV_DONE: begin
        busy_s  = 1'b0;
        state_s = DIV_IDLE;
      end
      default: begin
        busy_s  = 1'b0;
        state_s = DIV_IDLE;
      end
    endcase

    if (reset) begin
      busy_s = 1'b0;
    end else begin
      busy_s = busy_s;
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= DIV_IDLE;
      result_r  <= ZERO;
      rem_r     <= ZERO;
      quo_r     <= ZERO;
      dvsr_r    <= ZERO;
      cnt_r     <= CNT_ZRO;
      neg_q_r   <= 1'b0;
      neg_r_r   <= 1'b0;
      sel_rem_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      result_r  <= result_s;
      rem_r     <= rem_s;
      quo_r     <= quo_s;
      dvsr_r    <= dvsr_s;
      cnt_r     <= cnt_s;
      neg_q_r   <= neg_q_s;
      neg_r_r   <= neg_r_s;
      sel_rem_r <= sel_rem_s;
    end
  end

  assign result = result_r;
  assign busy   = busy_s;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit.
module tb_div_unit;
  import riscv_m_pkg::*;

  logic        clk;
  logic        reset;
  logic        ce;
  logic [2:0]  funct3;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] result;
  logic        busy;

  int vecs = 0;
  int errs = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .ce     (ce),
    .funct3 (funct3),
    .a      (a),
    .b      (b),
    .result (result),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op at the current cycle (called just after a rising edge, or
  // during DONE for a back-to-back issue). Counts busy cycles up to DONE,
  // scrambles a/b after issue, then checks busy length and result.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] av, input logic [31:0] bv,
                       input int exp_busy, input logic [31:0] exp_res,
                       input string tag, input bit hold);
    int n;
    ce = 1'b1; funct3 = f3; a = av; b = bv;
    n = 0;
    @(negedge clk);
    while (busy && n < 40) begin
      n++;
      @(posedge clk); #1;
      a = 32'hDEAD_BEEF; b = 32'h0000_1234;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, 32'(n), 32'(exp_busy));
    check({tag, "_result"}, result, exp_res);
    if (!hold) begin
      @(posedge clk); #1;
      ce = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1; ce = 1'b1; funct3 = F3_DIVU; a = 32'd100; b = 32'd7;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_result", result, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; ce = 1'b0;

    // Normal path
    do_op(F3_DIVU, 32'd100, 32'd7, 34, 32'd14, "divu_100_7", 1'b0);
    do_op(F3_REMU, 32'd100, 32'd7, 34, 32'd2, "remu_100_7", 1'b0);
    do_op(F3_DIV, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFD, "div_m7_2", 1'b0);
    do_op(F3_REM, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFF, "rem_m7_2", 1'b0);
    do_op(F3_DIV, 32'd100, 32'hFFFF_FFF9, 34, 32'hFFFF_FFF2, "div_100_m7", 1'b0);
    do_op(F3_REM, 32'd100, 32'hFFFF_FFF9, 34, 32'd2, "rem_100_m7", 1'b0);
    do_op(F3_DIVU, 32'hFFFF_FFFF, 32'd1, 34, 32'hFFFF_FFFF, "divu_max_1", 1'b0);
    do_op(F3_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'd0, "divu_min_ones", 1'b0);
    do_op(F3_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h8000_0000, "remu_min_ones", 1'b0);

    // Special cases: single busy cycle
    do_op(F3_DIV, 32'd5, 32'd0, 1, 32'hFFFF_FFFF, "div_by0", 1'b0);
    do_op(F3_REMU, 32'd5, 32'd0, 1, 32'd5, "remu_by0", 1'b0);
    do_op(F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, "div_ovf", 1'b0);
    do_op(F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0, "rem_ovf", 1'b0);
    do_op(F3_MUL, 32'd9, 32'd3, 1, 32'd0, "non_div", 1'b0);

    // Back-to-back with ce held across DONE
    do_op(F3_DIVU, 32'd100, 32'd7, 34, 32'd14, "b2b_first", 1'b1);
    do_op(F3_DIVU, 32'd81, 32'd9, 34, 32'd9, "b2b_second", 1'b0);

    // Abort: drop ce at N+10, result keeps 9
    ce = 1'b1; funct3 = F3_DIVU; a = 32'd100; b = 32'd7;
    repeat (10) @(posedge clk);
    #1 ce = 1'b0;
    @(negedge clk);
    check("abort_busy_n10", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("abort_busy_n11", {31'd0, busy}, 32'd0);
    check("abort_result_kept", result, 32'd9);
    @(posedge clk); #1;
    do_op(F3_DIVU, 32'd81, 32'd9, 34, 32'd9, "after_abort", 1'b0);
    do_op(F3_REMU, 32'd100, 32'd7, 34, 32'd2, "pre_reset", 1'b0);

    // Reset mid-operation at N+5
    ce = 1'b1; funct3 = F3_DIVU; a = 32'd100; b = 32'd7;
    repeat (5) @(posedge clk);
    #1 reset = 1'b1; ce = 1'b0;
    @(negedge clk);
    check("midreset_busy_n5", {31'd0, busy}, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("midreset_busy_n6", {31'd0, busy}, 32'd0);
    check("midreset_result_n6", result, 32'd0);
    @(posedge clk); #1;
    do_op(F3_REMU, 32'd100, 32'd7, 34, 32'd2, "after_reset", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
